// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory-port arbiter slice.
//   arb_mode_e     : arbitration policy selector (round-robin / fixed priority)
//   ch_id_w()      : width of an encoded channel id, never less than one bit
//   DEF_DATA_W/ADDR_W : default memory data / word-address widths
package mem_port_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 14;

    function automatic int ch_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_rr_arb.sv
// Per-cycle arbiter for the shared memory port.
//   clk, rst      : clock, synchronous active-high reset
//   req_i         : per-channel request vector
//   gnt_o         : one-hot grant (combinational, zero while rst is high)
//   gnt_id_o      : encoded winner id, meaningful when gnt_valid_o is high
//   gnt_valid_o   : some channel won this cycle
// Round-robin mode keeps a priority pointer; fixed mode favours the lowest index.
module mem_port_rr_arb
    import mem_port_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ARB_MODE = 0,
    localparam int ID_W    = ch_id_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [ID_W-1:0]   gnt_id_o,
    output logic              gnt_valid_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    int              idx;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        if (!rst) begin
            // Scan from the lowest priority upward so the highest-priority
            // requester is the last one written and therefore wins.
            for (int j = NUM_CH - 1; j >= 0; j--) begin
                if (ARB_MODE == int'(ARB_FIXED)) begin
                    idx = j;
                end else begin
                    idx = int'(ptr_q) + j;
                    if (idx >= NUM_CH) idx = idx - NUM_CH;
                end
                if (req_i[idx]) begin
                    gnt_id_o    = ID_W'(idx);
                    gnt_valid_o = 1'b1;
                end
            end
        end
        gnt_o = gnt_valid_o ? (NUM_CH'(1) << gnt_id_o) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o && ARB_MODE != int'(ARB_FIXED)) begin
            ptr_d = (int'(gnt_id_o) == NUM_CH - 1) ? '0 : gnt_id_o + ID_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter sharing one single-port memory.
//   clk, rst        : clock, synchronous active-high reset
//   ch_req/ch_we    : per-channel request and write enable
//   ch_addr/ch_wdata: packed per-channel address / write data
//   ch_gnt          : one-hot combinational grant
//   ch_rvalid       : one-hot read-return strobe for the issuing channel
//   ch_rdata        : read data, broadcast, qualified by ch_rvalid
//   mem_en/mem_we/mem_addr/mem_data_i : registered command to the memory
//   mem_data_o      : read data from the memory, RD_LAT cycles after mem_en
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_rvalid,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data_i,
    input  logic [DATA_W-1:0]        mem_data_o
);

    localparam int ID_W = ch_id_w(NUM_CH);

    logic [ID_W-1:0]   win_id;
    logic              win_valid;

    logic              cmd_en_q, cmd_en_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic [ID_W-1:0]   cmd_id_q, cmd_id_d;

    // Read-return pipeline: stage 0 tracks the command on the port this
    // cycle, stage RD_LAT-1 lines up with mem_data_o.
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [ID_W-1:0]   pid_q [RD_LAT];
    logic [ID_W-1:0]   pid_d [RD_LAT];

    mem_port_rr_arb #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (ch_req),
        .gnt_o       (ch_gnt),
        .gnt_id_o    (win_id),
        .gnt_valid_o (win_valid)
    );

    // Address and write data hold when idle; only en/we drop.
    always_comb begin
        cmd_en_d   = win_valid;
        cmd_we_d   = 1'b0;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_id_d   = cmd_id_q;
        if (win_valid) begin
            cmd_we_d   = ch_we[win_id];
            cmd_addr_d = ch_addr[int'(win_id)*ADDR_W +: ADDR_W];
            cmd_data_d = ch_wdata[int'(win_id)*DATA_W +: DATA_W];
            cmd_id_d   = win_id;
        end
    end

    always_comb begin
        pv_d     = pv_q;
        pid_d    = pid_q;
        pv_d[0]  = cmd_en_q & ~cmd_we_q;
        pid_d[0] = cmd_id_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_en_q   <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            pv_q       <= '0;
        end else begin
            cmd_en_q   <= cmd_en_d;
            cmd_we_q   <= cmd_we_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            pv_q       <= pv_d;
        end
    end

    // NOTE: channel ids are only ever looked at alongside a valid bit, so
    // they carry no reset; clearing the valids is enough to kill in-flight reads.
    always_ff @(posedge clk) begin
        cmd_id_q <= cmd_id_d;
        pid_q    <= pid_d;
    end

    assign mem_en     = cmd_en_q;
    assign mem_we     = cmd_we_q;
    assign mem_addr   = cmd_addr_q;
    assign mem_data_i = cmd_data_q;
    assign ch_rvalid  = pv_q[RD_LAT-1] ? (NUM_CH'(1) << pid_q[RD_LAT-1]) : '0;
    assign ch_rdata   = mem_data_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three instances share one stimulus stream:
//   0: round-robin, RD_LAT=1   1: fixed priority, RD_LAT=1   2: round-robin, RD_LAT=3
// A cycle-level model (pointer, scheduled read returns by cycle number)
// predicts every output of every instance; directed checks pin key cycles.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 14;
    localparam int NI = 3;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    req, we;
    logic [AW-1:0]   addr [N];
    logic [DW-1:0]   wd [N];
    logic [DW-1:0]   mem_rd;
    logic [N*AW-1:0] addr_bus;
    logic [N*DW-1:0] wd_bus;

    logic [N-1:0]  gnt_w [NI];
    logic [N-1:0]  rv_w  [NI];
    logic [DW-1:0] rd_w  [NI];
    logic [DW-1:0] md_w  [NI];
    logic [AW-1:0] ad_w  [NI];
    logic          en_w  [NI];
    logic          mwe_w [NI];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_bus[i*AW +: AW] = addr[i];
            wd_bus[i*DW +: DW]   = wd[i];
        end
    end

    mem_port_arbiter #(.NUM_CH(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .ARB_MODE(0)) u_rr1 (
        .clk(clk), .rst(rst), .ch_req(req), .ch_we(we), .ch_addr(addr_bus), .ch_wdata(wd_bus),
        .ch_gnt(gnt_w[0]), .ch_rvalid(rv_w[0]), .ch_rdata(rd_w[0]), .mem_en(en_w[0]),
        .mem_we(mwe_w[0]), .mem_addr(ad_w[0]), .mem_data_i(md_w[0]), .mem_data_o(mem_rd));

    mem_port_arbiter #(.NUM_CH(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .ARB_MODE(1)) u_fp1 (
        .clk(clk), .rst(rst), .ch_req(req), .ch_we(we), .ch_addr(addr_bus), .ch_wdata(wd_bus),
        .ch_gnt(gnt_w[1]), .ch_rvalid(rv_w[1]), .ch_rdata(rd_w[1]), .mem_en(en_w[1]),
        .mem_we(mwe_w[1]), .mem_addr(ad_w[1]), .mem_data_i(md_w[1]), .mem_data_o(mem_rd));

    mem_port_arbiter #(.NUM_CH(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .ARB_MODE(0)) u_rr3 (
        .clk(clk), .rst(rst), .ch_req(req), .ch_we(we), .ch_addr(addr_bus), .ch_wdata(wd_bus),
        .ch_gnt(gnt_w[2]), .ch_rvalid(rv_w[2]), .ch_rdata(rd_w[2]), .mem_en(en_w[2]),
        .mem_we(mwe_w[2]), .mem_addr(ad_w[2]), .mem_data_i(md_w[2]), .mem_data_o(mem_rd));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int lat_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic bit fixed_of(input int k);
        return (k == 1);
    endfunction

    int            cyc = 0;
    bit            model_ok = 1'b0;
    int            ptr_m [NI];
    logic          en_m  [NI];
    logic          we_m  [NI];
    logic [AW-1:0] ad_m  [NI];
    logic [DW-1:0] wd_m  [NI];
    bit            rv_sched [NI][MAXC];
    int            rv_id    [NI][MAXC];

    function automatic int winner(input int k);
        if (rst) return -1;
        for (int j = 0; j < N; j++) begin
            int c;
            c = fixed_of(k) ? j : (ptr_m[k] + j) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int w;
            logic [N-1:0] eg, erv;
            w   = winner(k);
            eg  = (w < 0) ? '0 : (N'(1) << w);
            erv = rv_sched[k][cyc] ? (N'(1) << rv_id[k][cyc]) : '0;
            if (model_ok) begin
                check($sformatf("gnt[%0d]", k),    gnt_w[k], eg);
                check($sformatf("mem_en[%0d]", k), en_w[k],  en_m[k]);
                check($sformatf("mem_we[%0d]", k), mwe_w[k], we_m[k]);
                check($sformatf("addr[%0d]", k),   ad_w[k],  ad_m[k]);
                check($sformatf("wdata[%0d]", k),  md_w[k],  wd_m[k]);
                check($sformatf("rvalid[%0d]", k), rv_w[k],  erv);
                if (erv != '0) check($sformatf("rdata[%0d]", k), rd_w[k], mem_rd);
            end
            if (rst) begin
                en_m[k]  = 1'b0;
                we_m[k]  = 1'b0;
                ad_m[k]  = '0;
                wd_m[k]  = '0;
                ptr_m[k] = 0;
                for (int d = cyc + 1; d < MAXC; d++) rv_sched[k][d] = 1'b0;
            end else if (w >= 0) begin
                en_m[k] = 1'b1;
                we_m[k] = we[w];
                ad_m[k] = addr[w];
                wd_m[k] = wd[w];
                if (!fixed_of(k)) ptr_m[k] = (w + 1) % N;
                if (!we[w] && cyc + 1 + lat_of(k) < MAXC) begin
                    rv_sched[k][cyc + 1 + lat_of(k)] = 1'b1;
                    rv_id[k][cyc + 1 + lat_of(k)]    = w;
                end
            end else begin
                en_m[k] = 1'b0;
                we_m[k] = 1'b0;
            end
        end
        if (rst) model_ok = 1'b1;
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
        mem_rd = {8'h5A, 24'(cyc)};
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        req = '0;
        we  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < N; i++) begin
            addr[i] = '0;
            wd[i]   = '0;
        end
        mem_rd = '0;
        nxt();
        nxt();
        mid();
        check("reset mem_en", en_w[0], 1'b0);
        check("reset rvalid", rv_w[2], 4'b0000);
        check("reset addr",   ad_w[0], 14'h0);
        nxt();
        rst = 1'b0;

        // Single read from channel 2
        addr[2] = 14'h0A5;
        req     = 4'b0100;
        mid();
        check("rd gnt", gnt_w[0], 4'b0100);
        nxt();
        idle();
        mid();
        check("rd mem_en",   en_w[0],  1'b1);
        check("rd mem_we",   mwe_w[0], 1'b0);
        check("rd mem_addr", ad_w[0],  14'h0A5);
        nxt();
        mem_rd = 32'hDEADBEEF;
        mid();
        check("rd rvalid", rv_w[0], 4'b0100);
        check("rd rdata",  rd_w[0], 32'hDEADBEEF);
        nxt();

        // Single write from channel 1
        addr[1] = 14'h3FFF;
        wd[1]   = 32'h12345678;
        req     = 4'b0010;
        we      = 4'b0010;
        mid();
        check("wr gnt", gnt_w[0], 4'b0010);
        nxt();
        idle();
        mid();
        check("wr mem_we",   mwe_w[0], 1'b1);
        check("wr mem_addr", ad_w[0],  14'h3FFF);
        check("wr mem_data", md_w[0],  32'h12345678);
        for (int i = 0; i < 3; i++) begin
            nxt();
            mid();
            check("wr no rvalid", rv_w[0], 4'b0000);
        end
        nxt();

        // Round-robin fairness straight after reset
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < N; i++) addr[i] = 14'h100 + 14'(i);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            mid();
            check("rr gnt lat1", gnt_w[0], 4'(1) << (i % 4));
            check("rr gnt lat3", gnt_w[2], 4'(1) << (i % 4));
            check("fp gnt all",  gnt_w[1], 4'b0001);
            if (i > 0) check("rr addr", ad_w[0], 14'h100 + 14'((i - 1) % 4));
            nxt();
        end
        idle();

        // Fixed priority: channel 0 starves channel 3 until it drops
        req = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("fp gnt ch0", gnt_w[1], 4'b0001);
            nxt();
        end
        req = 4'b1000;
        mid();
        check("fp gnt ch3", gnt_w[1], 4'b1000);
        nxt();
        idle();
        repeat (5) nxt();

        // Read latency pipeline: ch3, ch0, ch1 back to back
        addr[3] = 14'h333;
        addr[0] = 14'h000;
        addr[1] = 14'h111;
        req = 4'b1000;
        nxt();
        req = 4'b0001;
        nxt();
        req = 4'b0010;
        mid();
        check("lat1 rvalid ch3", rv_w[0], 4'b1000);
        nxt();
        idle();
        nxt();
        mid();
        check("lat3 rvalid t+4", rv_w[2], 4'b1000);
        nxt();
        mid();
        check("lat3 rvalid t+5", rv_w[2], 4'b0001);
        nxt();
        mid();
        check("lat3 rvalid t+6", rv_w[2], 4'b0010);
        nxt();
        repeat (4) nxt();

        // Reset while a read is in flight
        addr[2] = 14'h055;
        req     = 4'b0100;
        nxt();
        idle();
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        req = 4'b1111;
        mid();
        check("rst mem_en",   en_w[2],  1'b0);
        check("rst ptr lat1", gnt_w[0], 4'b0001);
        check("rst ptr lat3", gnt_w[2], 4'b0001);
        nxt();
        idle();
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rst no rvalid", rv_w[2], 4'b0000);
            nxt();
        end

        // Mixed traffic checked against the model alone
        repeat (40) begin
            req = 4'($urandom);
            we  = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                addr[i] = AW'($urandom);
                wd[i]   = $urandom;
            end
            nxt();
        end
        idle();
        repeat (6) nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
